// File: rtl/rob_pkg.sv
// rob_pkg: ROB sizing shared by the ROB, decode and the allocation controller
package rob_pkg;
  localparam int ROB_ENTRIES = 10;
  localparam int ROB_IDX_W = 4;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0] rob_cnt_t;
  function automatic rob_idx_t rob_inc(input rob_idx_t i);
    return (i == rob_idx_t'(ROB_ENTRIES - 1)) ? '0 : i + rob_idx_t'(1);
  endfunction
endpackage

// File: rtl/rob_alloc_ctrl_if.sv
// rob_alloc_ctrl_if: decode <-> ROB allocation handshake; perf counters appear with ROB_ALLOC_PERF_EN
interface rob_alloc_ctrl_if;
  import rob_pkg::*;
  logic in_alloc_req;
  logic in_commit;
  logic in_flush;
  logic out_alloc_grant;
  rob_idx_t out_alloc_idx;
  rob_idx_t out_head_idx;
  rob_cnt_t out_count;
  logic out_full;
  logic out_empty;
  logic out_stall_decode;
`ifdef ROB_ALLOC_PERF_EN
  logic [31:0] out_full_stall_cycles;
  logic [15:0] out_flush_count;
  modport master (
    output in_alloc_req, in_commit, in_flush,
    input out_alloc_grant, out_alloc_idx, out_head_idx, out_count, out_full, out_empty,
    input out_stall_decode, out_full_stall_cycles, out_flush_count
  );
  modport slave (
    input in_alloc_req, in_commit, in_flush,
    output out_alloc_grant, out_alloc_idx, out_head_idx, out_count, out_full, out_empty,
    output out_stall_decode, out_full_stall_cycles, out_flush_count
  );
`else
  modport master (
    output in_alloc_req, in_commit, in_flush,
    input out_alloc_grant, out_alloc_idx, out_head_idx, out_count, out_full, out_empty,
    input out_stall_decode
  );
  modport slave (
    input in_alloc_req, in_commit, in_flush,
    output out_alloc_grant, out_alloc_idx, out_head_idx, out_count, out_full, out_empty,
    output out_stall_decode
  );
`endif
endinterface

// File: rtl/rob_wrap_ptr.sv
// rob_wrap_ptr: ROB pointer that wraps at ROB_ENTRIES-1 back to 0, with synchronous clear
module rob_wrap_ptr
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     inc_i,
  input  logic     clr_i,
  output rob_idx_t ptr_o
);
  rob_idx_t ptr_q, ptr_d;
  // clear beats increment so a flush always lands on slot 0
  always_comb ptr_d = clr_i ? '0 : inc_i ? rob_inc(ptr_q) : ptr_q;
  // pointer register
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: hands decode ROB slots, tracks occupancy, stalls when full; perf counters under ROB_ALLOC_PERF_EN
module rob_alloc_ctrl
  import rob_pkg::*;
(
  input logic             clk,
  input logic             reset,
  rob_alloc_ctrl_if.slave bus
);
  rob_idx_t head, tail;
  rob_cnt_t count_q, count_d;
  logic full, empty, commit_eff, grant, stall;
  assign full = count_q == rob_cnt_t'(ROB_ENTRIES);
  assign empty = count_q == '0;
  assign commit_eff = bus.in_commit && !empty && !bus.in_flush;
  assign grant = bus.in_alloc_req && !bus.in_flush && (!full || commit_eff);
  assign stall = bus.in_alloc_req && !grant;
  rob_wrap_ptr u_head (.clk(clk), .reset(reset), .inc_i(commit_eff), .clr_i(bus.in_flush), .ptr_o(head));
  rob_wrap_ptr u_tail (.clk(clk), .reset(reset), .inc_i(grant), .clr_i(bus.in_flush), .ptr_o(tail));
  // occupancy: a same-cycle grant and commit cancel out; flush empties the ROB
  always_comb count_d = bus.in_flush ? '0 : count_q + rob_cnt_t'(grant) - rob_cnt_t'(commit_eff);
  // occupancy register
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign bus.out_alloc_grant = grant;
  assign bus.out_alloc_idx = tail;
  assign bus.out_head_idx = head;
  assign bus.out_count = count_q;
  assign bus.out_full = full;
  assign bus.out_empty = empty;
  assign bus.out_stall_decode = stall;
`ifdef ROB_ALLOC_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  // stall counter saturates, flush counter wraps
  always_comb begin
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = flush_cnt_q + 16'(bus.in_flush);
  end
  // perf counters, cleared only by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign bus.out_full_stall_cycles = stall_cnt_q;
  assign bus.out_flush_count = flush_cnt_q;
`endif
endmodule
